// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
// Module   : fetch_stage
// Purpose  : Instruction fetch stage. Owns the program counter, drives a
//            byte-addressed instruction memory with a one-cycle registered
//            read, and presents instruction / PC+4 / valid to the IF/ID
//            boundary. Supports ID stall and EX branch redirect, and counts
//            issued reads.
// Ports    : clk            - clock, all state on rising edge
//            rst            - synchronous active-low reset (0 = reset)
//            stall          - freeze fetch (ignored when branch_taken=1)
//            branch_taken   - redirect request
//            branch_addr    - redirect target, bits [1:0] ignored
//            mem_read_data  - ReadData from instruction memory
//            mem_address    - combinational address to memory
//            mem_read       - combinational MemRead to memory
//            instruction    - fetched instruction (straight from memory)
//            pc_out         - address of presented instruction + 4
//            valid          - instruction/pc_out belong to a live fetch
//            fetch_count    - reads issued since reset (wraps)
// Revision : 1.0 - initial release
// ============================================================================
module fetch_stage #(
  parameter int                    ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stall,
  input  logic                  branch_taken,
  input  logic [ADDR_WIDTH-1:0] branch_addr,
  input  logic [31:0]           mem_read_data,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic                  mem_read,
  output logic [31:0]           instruction,
  output logic [ADDR_WIDTH-1:0] pc_out,
  output logic                  valid,
  output logic [31:0]           fetch_count
);

  localparam logic [0:0]            c_ST_BOOT = 1'b0;
  localparam logic [0:0]            c_ST_RUN  = 1'b1;
  localparam logic [ADDR_WIDTH-1:0] c_PC_STEP = ADDR_WIDTH'(4);

  logic [0:0]            r_state;
  logic [ADDR_WIDTH-1:0] r_pc;
  logic [ADDR_WIDTH-1:0] r_resp_pc;
  logic                  r_valid;
  logic [31:0]           r_fetch_count;

  logic [ADDR_WIDTH-1:0] w_tgt;
  logic [ADDR_WIDTH-1:0] w_mem_address;
  logic                  w_mem_read;
  logic                  w_unused_addr_bits;

  // Branch targets are forced to word alignment; the low bits carry no meaning.
  assign w_tgt              = {branch_addr[ADDR_WIDTH-1:2], 2'b00};
  assign w_unused_addr_bits = ^branch_addr[1:0];

  // Issue decision. BOOT suppresses the read so the memory gets its
  // reset-load cycle. A branch overrides a concurrent stall.
  always_comb begin
    w_mem_address = r_pc;
    w_mem_read    = 1'b0;
    if (rst && (r_state == c_ST_RUN)) begin
      if (branch_taken) begin
        w_mem_address = w_tgt;
        w_mem_read    = 1'b1;
      end else if (!stall) begin
        w_mem_read    = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state       <= c_ST_BOOT;
      r_pc          <= RESET_PC;
      r_resp_pc     <= '0;
      r_valid       <= 1'b0;
      r_fetch_count <= '0;
    end else begin
      r_state <= c_ST_RUN;
      // With no read issued everything holds; memory also holds ReadData,
      // so the presented instruction is stable through a stall.
      if (w_mem_read) begin
        r_pc          <= w_mem_address + c_PC_STEP;
        r_resp_pc     <= w_mem_address;
        r_valid       <= 1'b1;
        r_fetch_count <= r_fetch_count + 32'd1;
      end
    end
  end

  assign mem_address = w_mem_address;
  assign mem_read    = w_mem_read;
  assign instruction = mem_read_data;
  assign pc_out      = r_resp_pc + c_PC_STEP;
  assign valid       = r_valid;
  assign fetch_count = r_fetch_count;

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_stage
// Purpose  : Self-checking bench for fetch_stage with a registered-read
//            big-endian instruction memory model and a behavioural fetch model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_stage;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_addr;
  logic [31:0] mem_read_data;
  logic [31:0] mem_address;
  logic        mem_read;
  logic [31:0] instruction;
  logic [31:0] pc_out;
  logic        valid;
  logic [31:0] fetch_count;

  int checks   = 0;
  int failures = 0;

  fetch_stage #(.ADDR_WIDTH(32), .RESET_PC(32'h0)) dut (
    .clk          (clk),
    .rst          (rst),
    .stall        (stall),
    .branch_taken (branch_taken),
    .branch_addr  (branch_addr),
    .mem_read_data(mem_read_data),
    .mem_address  (mem_address),
    .mem_read     (mem_read),
    .instruction  (instruction),
    .pc_out       (pc_out),
    .valid        (valid),
    .fetch_count  (fetch_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- instruction memory (big-endian bytes) ----------------
  logic [7:0] img [0:15];
  initial begin
    {img[0],  img[1],  img[2],  img[3]}  = 32'hE0000000;
    {img[4],  img[5],  img[6],  img[7]}  = 32'hE3A00014;
    {img[8],  img[9],  img[10], img[11]} = 32'hE3A01801;
    {img[12], img[13], img[14], img[15]} = 32'hE0912000;
  end

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a < 32'd16)
      return {img[a[3:0]], img[a[3:0] + 4'd1], img[a[3:0] + 4'd2], img[a[3:0] + 4'd3]};
    return (a * 32'h9E3779B1) ^ 32'h5A5A0000;
  endfunction

  always @(posedge clk) begin
    if (!rst)          mem_read_data <= 32'h0;
    else if (mem_read) mem_read_data <= mem_word(mem_address);
  end

  // ---------------- behavioural fetch model ----------------
  logic [31:0] m_pc;       // next sequential fetch address
  logic        m_boot;     // first cycle after reset release
  logic        m_valid;
  logic [31:0] m_last;     // address of the most recent issued read
  logic [31:0] m_count;
  logic        e_rd;       // expected issue this cycle
  logic [31:0] e_addr;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
    end
  endtask

  // Apply inputs for the coming edge and check the combinational issue.
  task automatic drive(input logic r, input logic s, input logic b, input logic [31:0] ba);
    rst = r; stall = s; branch_taken = b; branch_addr = ba;
    if (!r || m_boot)  begin e_rd = 1'b0; e_addr = m_pc; end
    else if (b)        begin e_rd = 1'b1; e_addr = ba & 32'hFFFF_FFFC; end
    else if (s)        begin e_rd = 1'b0; e_addr = m_pc; end
    else               begin e_rd = 1'b1; e_addr = m_pc; end
    #1;
    chk("model_mem_read", {31'b0, mem_read}, {31'b0, e_rd});
    chk("model_mem_address", mem_address, e_addr);
  endtask

  // Clock edge, advance model, then check registered outputs.
  task automatic tick();
    @(posedge clk);
    if (!rst) begin
      m_pc = 32'h0; m_boot = 1'b1; m_valid = 1'b0; m_last = 32'h0; m_count = 32'h0;
    end else begin
      m_boot = 1'b0;
      if (e_rd) begin
        m_last  = e_addr;
        m_pc    = e_addr + 32'd4;
        m_valid = 1'b1;
        m_count = m_count + 32'd1;
      end
    end
    @(negedge clk);
    chk("model_valid", {31'b0, valid}, {31'b0, m_valid});
    chk("model_fetch_count", fetch_count, m_count);
    chk("model_pc_out", pc_out, m_last + 32'd4);
    if (m_valid) chk("model_instruction", instruction, mem_word(m_last));
  endtask

  task automatic cyc(input logic r, input logic s, input logic b, input logic [31:0] ba);
    drive(r, s, b, ba);
    tick();
  endtask

  initial begin
    rst = 1'b0; stall = 1'b0; branch_taken = 1'b0; branch_addr = 32'h0;
    m_pc = 32'h0; m_boot = 1'b1; m_valid = 1'b0; m_last = 32'h0; m_count = 32'h0;
    e_rd = 1'b0; e_addr = 32'h0;
    @(negedge clk);

    // Reset held two cycles.
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
    chk("reset_valid", {31'b0, valid}, 32'd0);
    chk("reset_count", fetch_count, 32'd0);

    // Release: BOOT cycle, no read.
    drive(1, 0, 0, 0);
    chk("boot_mem_read", {31'b0, mem_read}, 32'd0);
    tick();
    chk("boot_valid", {31'b0, valid}, 32'd0);

    // First fetch from address 0.
    drive(1, 0, 0, 0);
    chk("first_addr", mem_address, 32'h0);
    chk("first_rd", {31'b0, mem_read}, 32'd1);
    tick();
    chk("first_instr", instruction, 32'hE0000000);
    chk("first_pc_out", pc_out, 32'd4);
    chk("first_valid", {31'b0, valid}, 32'd1);
    chk("first_count", fetch_count, 32'd1);

    cyc(1, 0, 0, 0);
    chk("second_instr", instruction, 32'hE3A00014);
    chk("second_pc_out", pc_out, 32'd8);

    // Stall 3 cycles while E3A00014 is presented.
    for (int i = 0; i < 3; i++) begin
      drive(1, 1, 0, 0);
      chk("stall_rd", {31'b0, mem_read}, 32'd0);
      tick();
      chk("stall_instr", instruction, 32'hE3A00014);
      chk("stall_pc_out", pc_out, 32'd8);
      chk("stall_count", fetch_count, 32'd2);
    end

    // Branch to 0x0E (pc=8) -> issue 0x0C.
    drive(1, 0, 1, 32'h0000000E);
    chk("br_addr", mem_address, 32'h0C);
    tick();
    chk("br_instr", instruction, 32'hE0912000);
    chk("br_pc_out", pc_out, 32'h10);
    drive(1, 0, 0, 0);
    chk("br_next_addr", mem_address, 32'h10);
    tick();

    // Branch during stall wins.
    drive(1, 1, 1, 32'h4);
    chk("brstall_rd", {31'b0, mem_read}, 32'd1);
    chk("brstall_addr", mem_address, 32'h4);
    tick();
    chk("brstall_instr", instruction, 32'hE3A00014);
    chk("brstall_pc_out", pc_out, 32'd8);
    cyc(1, 0, 0, 0);
    chk("after_brstall_instr", instruction, 32'hE3A01801);
    chk("after_brstall_count", fetch_count, 32'd6);

    // Address wrap: target FFFFFFFF aligns to FFFFFFFC, next pc wraps to 0.
    drive(1, 0, 1, 32'hFFFF_FFFF);
    chk("wrap_addr", mem_address, 32'hFFFF_FFFC);
    tick();
    chk("wrap_pc_out", pc_out, 32'h0);
    drive(1, 0, 0, 0);
    chk("wrap_next_addr", mem_address, 32'h0);
    tick();

    // Mid-run reset for one edge, then boot and restart from 0 streaming.
    drive(0, 0, 0, 0);
    chk("midrst_rd", {31'b0, mem_read}, 32'd0);
    tick();
    chk("midrst_valid", {31'b0, valid}, 32'd0);
    chk("midrst_count", fetch_count, 32'd0);
    drive(1, 0, 0, 0);
    chk("midrst_boot_rd", {31'b0, mem_read}, 32'd0);
    tick();
    for (int i = 0; i < 4; i++) begin
      drive(1, 0, 0, 0);
      chk("stream_addr", mem_address, 32'(i * 4));
      tick();
      chk("stream_pc_out", pc_out, 32'(i * 4 + 4));
    end
    chk("stream_instr_last", instruction, 32'hE0912000);
    chk("stream_count", fetch_count, 32'd4);

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      logic        r, s, b;
      logic [31:0] ba;
      r  = ($urandom_range(0, 39) != 0);
      s  = ($urandom_range(0, 3) == 0);
      b  = ($urandom_range(0, 5) == 0);
      case ($urandom_range(0, 2))
        0:       ba = $urandom_range(0, 15);
        1:       ba = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
        default: ba = $urandom;
      endcase
      cyc(r, s, b, ba);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction fetch (IF) stage of the ARM pipeline.
- Owns the program counter and drives the byte-addressed, big-endian instruction memory. That memory has a one-cycle registered read: `ReadData` updates at the clock edge where `MemRead` is high and holds otherwise.
- Presents the fetched instruction, PC+4 and a valid flag to the IF/ID boundary.
- Handles pipeline stall and branch redirect from downstream stages, and keeps a fetch counter.

Parameters:
- ADDR_WIDTH, 32, width of PC and memory address.
- RESET_PC, 0, PC loaded on reset; must be word-aligned.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-low reset. Sampled on clk rising edge; 0 = reset.
- stall  input  1  hazard stall from ID; freezes fetch.
- branch_taken  input  1  redirect request from EX.
- branch_addr  input  ADDR_WIDTH  redirect target byte address.
- mem_read_data  input  32  `ReadData` from instruction memory.
- mem_address  output  ADDR_WIDTH  address to instruction memory (combinational).
- mem_read  output  1  `MemRead` to instruction memory (combinational).
- instruction  output  32  fetched instruction; wired directly from mem_read_data.
- pc_out  output  ADDR_WIDTH  address of instruction + 4.
- valid  output  1  instruction/pc_out are a live fetch.
- fetch_count  output  32  number of reads issued since reset.

Behaviour:
- State machine: BOOT, RUN.
  - Reset → BOOT.
  - BOOT → RUN unconditionally after one cycle. In BOOT, mem_read=0, which gives instruction memory its reset-load cycle.
  - RUN has no exit except reset.
- Reset (rst=0 at edge):
  - pc ← RESET_PC, resp_pc ← 0, valid ← 0, fetch_count ← 0, state ← BOOT.
  - While rst=0: mem_read=0, mem_address=pc.
  - A reset mid-operation discards any in-flight fetch; valid is 0 in the cycle after the reset edge.
- Target address tgt = {branch_addr[ADDR_WIDTH-1:2], 2'b00}; bits [1:0] are ignored.
- Issue condition (combinational, rst=1, state=RUN):
  - branch_taken=1: mem_address=tgt, mem_read=1. This applies regardless of stall; branch wins over stall.
  - else stall=1: mem_address=pc, mem_read=0.
  - else: mem_address=pc, mem_read=1.
- Edge update when mem_read=1:
  - pc ← mem_address+4 (modulo 2^ADDR_WIDTH, wraps silently).
  - resp_pc ← mem_address.
  - valid ← 1.
  - fetch_count ← fetch_count+1 (wraps).
- Edge update when mem_read=0 (stall or BOOT): pc, resp_pc, valid and fetch_count hold. Memory holds `ReadData`, so instruction is stable for the whole stall.
- Outputs:
  - pc_out = resp_pc+4 (combinational).
  - instruction = mem_read_data.
- Latency: an address issued in cycle n yields instruction/valid/pc_out in cycle n+1. Throughput is one instruction per cycle.
- Branch penalty:
  - The instruction presented in the branch cycle belongs to the wrong path. The EX/ID flush logic squashes it; this block does not.
  - The target instruction appears in the next cycle, so the penalty is 1 bubble.
- stall and branch_taken in the same cycle: branch taken, stall ignored for that cycle.
- The block never writes memory; the top level ties `MemWrite`=0. The top level also adapts the memory's active-high reset from rst.

Test Plan:
Memory image for all scenarios: word0=E0000000, word4=E3A00014, word8=E3A01801, word12=E0912000.
- Reset/boot: hold rst=0 for 2 cycles, then release.
  - → valid=0 and mem_read=0 for the release cycle (BOOT).
  - Next cycle: mem_address=0, mem_read=1.
  - One cycle later: instruction=E0000000, pc_out=4, valid=1, fetch_count=1.
- Streaming: run with no stall/branch.
  - → consecutive cycles deliver E0000000, E3A00014, E3A01801, E0912000 with pc_out 4, 8, 12, 16.
  - fetch_count=4 after the 4th issue.
- Stall: assert stall for 3 cycles while instruction=E3A00014.
  - → instruction, pc_out=8 and valid hold; mem_read=0; fetch_count unchanged.
  - After stall drops, the next instruction is E3A01801.
- Branch: branch_taken=1, branch_addr=0x0000000E while pc=8.
  - → mem_address=0x0C same cycle.
  - Next cycle: instruction=E0912000, pc_out=0x10.
  - Following issue address is 0x10.
- Branch during stall: stall=1 and branch_taken=1, branch_addr=4.
  - → mem_read=1, mem_address=4.
  - Next cycle: instruction=E3A00014, pc_out=8.
- Mid-run reset: drive rst=0 for one edge while streaming.
  - → next cycle valid=0, fetch_count=0, BOOT repeats.
  - Fetch restarts at RESET_PC.
